// File: rtl/xsleena_video_pkg.sv
// Shared types and constants for the XSleena video output stage.
//   geom_state_t : geometry lock FSM states
//   geom_t       : one frame's measured geometry (zero-extended counts)
//   XS_*         : nominal XSleena raster geometry
//   expand4      : 4-bit to 8-bit colour expansion
package xsleena_video_pkg;

  localparam int unsigned GEOM_W = 16;

  localparam int unsigned XS_H_TOTAL  = 384;
  localparam int unsigned XS_H_ACTIVE = 256;
  localparam int unsigned XS_V_TOTAL  = 272;
  localparam int unsigned XS_V_ACTIVE = 240;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } geom_state_t;

  typedef struct packed {
    logic [GEOM_W-1:0] h_total;
    logic [GEOM_W-1:0] h_active;
    logic [GEOM_W-1:0] v_total;
    logic [GEOM_W-1:0] v_active;
  } geom_t;

  // Replicate the nibble so 4'hF maps to full-scale 8'hFF.
  function automatic logic [7:0] expand4(input logic [3:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/xsleena_geom_meter.sv
// Measures line/frame geometry from CE-sampled sync and blank signals and
// publishes it once two consecutive frames agree.
//   clk, rst         : clock, async active-high reset
//   ce               : pixel clock enable
//   blk_n, vblk_n    : horizontal / vertical display windows (high = active)
//   hsync, vsync     : active-high syncs
//   h_total/h_active : published pixels per line
//   v_total/v_active : published lines per frame
//   locked           : published geometry matches the latest frame
module xsleena_geom_meter
  import xsleena_video_pkg::*;
#(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          blk_n,
  input  logic          vblk_n,
  input  logic          hsync,
  input  logic          vsync,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          locked
);

  logic          hs_prev, vs_prev;
  logic [HW-1:0] hcnt, hact, h_tot_cur, h_act_cur;
  logic [VW-1:0] vcnt, vact;
  logic          line_seen;
  geom_state_t   state;
  geom_t         cand;

  logic          hs_rise, vs_rise;
  logic [HW-1:0] hcnt_inc, hact_inc;
  logic [VW-1:0] vcnt_inc, vact_inc;
  geom_t         meas;

  // Edge detect, saturating increments, and the frame values as seen at this
  // CE: a line closed on this same CE is already folded into the frame.
  always_comb begin
    hs_rise  = ce & hsync & ~hs_prev;
    vs_rise  = ce & vsync & ~vs_prev;
    hcnt_inc = (hcnt == {HW{1'b1}}) ? hcnt : hcnt + HW'(1);
    hact_inc = (hact == {HW{1'b1}}) ? hact : hact + HW'(1);
    vcnt_inc = (vcnt == {VW{1'b1}}) ? vcnt : vcnt + VW'(1);
    vact_inc = (vact == {VW{1'b1}}) ? vact : vact + VW'(1);
    meas          = '0;
    meas.h_total  = GEOM_W'(hs_rise ? hcnt : h_tot_cur);
    meas.h_active = GEOM_W'(hs_rise ? hact : h_act_cur);
    meas.v_total  = GEOM_W'(hs_rise ? vcnt_inc : vcnt);
    meas.v_active = GEOM_W'((hs_rise && line_seen) ? vact_inc : vact);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_prev   <= 1'b0;
      vs_prev   <= 1'b0;
      hcnt      <= '0;
      hact      <= '0;
      h_tot_cur <= '0;
      h_act_cur <= '0;
      vcnt      <= '0;
      vact      <= '0;
      line_seen <= 1'b0;
      state     <= SEARCH;
      cand      <= '0;
      h_total   <= '0;
      h_active  <= '0;
      v_total   <= '0;
      v_active  <= '0;
      locked    <= 1'b0;
    end else if (ce) begin
      hs_prev <= hsync;
      vs_prev <= vsync;

      // Horizontal: the edge pixel is the first pixel of the new line.
      if (hs_rise) begin
        h_tot_cur <= hcnt;
        h_act_cur <= hact;
        hcnt      <= HW'(1);
        hact      <= blk_n ? HW'(1) : '0;
        line_seen <= blk_n & vblk_n;
      end else begin
        hcnt <= hcnt_inc;
        if (blk_n)          hact      <= hact_inc;
        if (blk_n & vblk_n) line_seen <= 1'b1;
      end

      // Vertical: a frame edge restarts the line counts after latching.
      if (vs_rise) begin
        vcnt <= '0;
        vact <= '0;
      end else if (hs_rise) begin
        vcnt <= vcnt_inc;
        vact <= meas.v_active[VW-1:0];
      end

      // Lock FSM: publish only after two consecutive matching frames.
      if (vs_rise) begin
        case (state)
          SEARCH: state <= MEASURE;
          MEASURE: begin
            cand  <= meas;
            state <= CONFIRM;
          end
          CONFIRM: begin
            if (meas == cand) begin
              h_total  <= meas.h_total[HW-1:0];
              h_active <= meas.h_active[HW-1:0];
              v_total  <= meas.v_total[VW-1:0];
              v_active <= meas.v_active[VW-1:0];
              locked   <= 1'b1;
              state    <= LOCKED;
            end else begin
              cand <= meas;
            end
          end
          LOCKED: begin
            if (meas != cand) begin
              locked <= 1'b0;
              cand   <= meas;
              state  <= CONFIRM;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: rtl/xsleena_video_out.sv
// XSleena video output stage: registers core video on CE, expands colour to
// 8 bits per channel, and reports measured raster geometry.
//   CLK, RST                    : clock, async active-high reset
//   CE_PIXEL                    : pixel clock enable
//   BLKn, VBLKn, HSYNC, VSYNC   : core timing
//   VIDEO_R/G/B                 : 4-bit core colour
//   R/G/B_OUT, DE, HS/VS_OUT    : registered video, 1 CE latency
//   HBLANK_OUT, VBLANK_OUT      : registered active-high blanks
//   CE_OUT                      : CE_PIXEL delayed one CLK
//   H_/V_TOTAL, H_/V_ACTIVE     : published geometry
//   LOCKED                      : geometry stable
module xsleena_video_out #(
  parameter int unsigned HW          = 10,
  parameter int unsigned VW          = 9,
  parameter bit          BLANK_BLACK = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE_PIXEL,
  input  logic          BLKn,
  input  logic          VBLKn,
  input  logic          HSYNC,
  input  logic          VSYNC,
  input  logic [3:0]    VIDEO_R,
  input  logic [3:0]    VIDEO_G,
  input  logic [3:0]    VIDEO_B,
  output logic [7:0]    R_OUT,
  output logic [7:0]    G_OUT,
  output logic [7:0]    B_OUT,
  output logic          DE,
  output logic          HS_OUT,
  output logic          VS_OUT,
  output logic          HBLANK_OUT,
  output logic          VBLANK_OUT,
  output logic          CE_OUT,
  output logic [HW-1:0] H_TOTAL,
  output logic [HW-1:0] H_ACTIVE,
  output logic [VW-1:0] V_TOTAL,
  output logic [VW-1:0] V_ACTIVE,
  output logic          LOCKED
);

  logic de_c;
  logic blank_c;

  always_comb begin
    de_c    = BLKn & VBLKn;
    blank_c = BLANK_BLACK & ~de_c;
  end

  // Single-stage pixel pipeline, advanced only on CE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      R_OUT      <= '0;
      G_OUT      <= '0;
      B_OUT      <= '0;
      DE         <= 1'b0;
      HS_OUT     <= 1'b0;
      VS_OUT     <= 1'b0;
      HBLANK_OUT <= 1'b0;
      VBLANK_OUT <= 1'b0;
      CE_OUT     <= 1'b0;
    end else begin
      CE_OUT <= CE_PIXEL;
      if (CE_PIXEL) begin
        R_OUT      <= blank_c ? 8'h00 : xsleena_video_pkg::expand4(VIDEO_R);
        G_OUT      <= blank_c ? 8'h00 : xsleena_video_pkg::expand4(VIDEO_G);
        B_OUT      <= blank_c ? 8'h00 : xsleena_video_pkg::expand4(VIDEO_B);
        DE         <= de_c;
        HS_OUT     <= HSYNC;
        VS_OUT     <= VSYNC;
        HBLANK_OUT <= ~BLKn;
        VBLANK_OUT <= ~VBLKn;
      end
    end
  end

  xsleena_geom_meter #(
    .HW(HW),
    .VW(VW)
  ) u_geom (
    .clk     (CLK),
    .rst     (RST),
    .ce      (CE_PIXEL),
    .blk_n   (BLKn),
    .vblk_n  (VBLKn),
    .hsync   (HSYNC),
    .vsync   (VSYNC),
    .h_total (H_TOTAL),
    .h_active(H_ACTIVE),
    .v_total (V_TOTAL),
    .v_active(V_ACTIVE),
    .locked  (LOCKED)
  );

endmodule

// File: tb/tb_xsleena_video_out.sv
// Directed bench for xsleena_video_out: pixel pipeline, blanking, lock
// acquisition/loss, coincident sync edges, counter saturation, mid-frame reset.
// Frames use the nominal 384/256 line with a short 10-line (8 active) frame.
module tb_xsleena_video_out;

  localparam int HTOT  = int'(xsleena_video_pkg::XS_H_TOTAL);
  localparam int HACT  = int'(xsleena_video_pkg::XS_H_ACTIVE);
  localparam int HSTART = 64;
  localparam int LINES = 10;
  localparam int VACT  = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE_PIXEL;
  logic       BLKn, VBLKn, HSYNC, VSYNC;
  logic [3:0] VIDEO_R, VIDEO_G, VIDEO_B;
  logic [7:0] R_OUT, G_OUT, B_OUT;
  logic       DE, HS_OUT, VS_OUT, HBLANK_OUT, VBLANK_OUT, CE_OUT, LOCKED;
  logic [9:0] H_TOTAL, H_ACTIVE;
  logic [8:0] V_TOTAL, V_ACTIVE;

  int checks = 0;
  int errors = 0;

  logic [31:0] pre_lk, post_lk, post_ht, post_ha, post_vt, post_va, post_vs;

  xsleena_video_out dut (
    .CLK(CLK), .RST(RST), .CE_PIXEL(CE_PIXEL),
    .BLKn(BLKn), .VBLKn(VBLKn), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
    .R_OUT(R_OUT), .G_OUT(G_OUT), .B_OUT(B_OUT), .DE(DE),
    .HS_OUT(HS_OUT), .VS_OUT(VS_OUT), .HBLANK_OUT(HBLANK_OUT),
    .VBLANK_OUT(VBLANK_OUT), .CE_OUT(CE_OUT),
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL),
    .V_ACTIVE(V_ACTIVE), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_px(input logic hs, input logic vs, input logic blk, input logic vblk);
    @(negedge CLK);
    HSYNC    = hs;
    VSYNC    = vs;
    BLKn     = blk;
    VBLKn    = vblk;
    VIDEO_R  = 4'h1;
    VIDEO_G  = 4'h2;
    VIDEO_B  = 4'h3;
    CE_PIXEL = 1'b1;
  endtask

  // One frame with HSYNC and VSYNC rising together on pixel (0,0); outputs
  // are captured right after that edge pixel is registered.
  task automatic run_frame(input int hlen, input int lastlen, input int nlines);
    pre_lk = 32'(LOCKED);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == LINES - 1) ? lastlen : hlen;
      for (int p = 0; p < len; p++) begin
        drive_px(p < 8, l < 2, (p >= HSTART) && (p < HSTART + HACT),
                 (l >= 1) && (l <= VACT));
        if (l == 0 && p == 0) begin
          @(posedge CLK);
          #1;
          post_lk = 32'(LOCKED);
          post_ht = 32'(H_TOTAL);
          post_ha = 32'(H_ACTIVE);
          post_vt = 32'(V_TOTAL);
          post_va = 32'(V_ACTIVE);
          post_vs = 32'(VS_OUT);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; CE_PIXEL = 1'b0;
    BLKn = 1'b1; VBLKn = 1'b1; HSYNC = 1'b1; VSYNC = 1'b0;
    VIDEO_R = 4'hF; VIDEO_G = 4'hF; VIDEO_B = 4'hF;

    // Reset holds everything at zero even with CE and live inputs.
    repeat (2) begin
      @(negedge CLK); CE_PIXEL = 1'b1;
    end
    @(posedge CLK); #1;
    chk("rst_r", 32'(R_OUT), 0);
    chk("rst_de", 32'(DE), 0);
    chk("rst_hs", 32'(HS_OUT), 0);
    chk("rst_hblank", 32'(HBLANK_OUT), 0);
    chk("rst_ce_out", 32'(CE_OUT), 0);
    chk("rst_locked", 32'(LOCKED), 0);
    chk("rst_h_total", 32'(H_TOTAL), 0);

    @(negedge CLK); RST = 1'b0; CE_PIXEL = 1'b0; HSYNC = 1'b0;
    @(negedge CLK);

    // First pixel: 1 CE latency and nibble replication.
    VIDEO_R = 4'h3; VIDEO_G = 4'h5; VIDEO_B = 4'hC; BLKn = 1'b1; VBLKn = 1'b1;
    CE_PIXEL = 1'b1;
    #1 chk("pre_ce_r", 32'(R_OUT), 0);
    @(posedge CLK); #1;
    chk("px1_r", 32'(R_OUT), 32'h33);
    chk("px1_g", 32'(G_OUT), 32'h55);
    chk("px1_b", 32'(B_OUT), 32'hCC);
    chk("px1_de", 32'(DE), 1);
    chk("px1_ce_out", 32'(CE_OUT), 1);
    chk("px1_vblank", 32'(VBLANK_OUT), 0);
    @(negedge CLK); CE_PIXEL = 1'b0;
    @(posedge CLK); #1;
    chk("px1_ce_out_low", 32'(CE_OUT), 0);
    chk("px1_r_hold", 32'(R_OUT), 32'h33);

    // Horizontal blank forces black.
    @(negedge CLK);
    VIDEO_R = 4'hF; VIDEO_G = 4'hF; VIDEO_B = 4'hF; BLKn = 1'b0; HSYNC = 1'b1;
    CE_PIXEL = 1'b1;
    @(posedge CLK); #1;
    chk("hblk_r", 32'(R_OUT), 0);
    chk("hblk_g", 32'(G_OUT), 0);
    chk("hblk_b", 32'(B_OUT), 0);
    chk("hblk_hblank", 32'(HBLANK_OUT), 1);
    chk("hblk_de", 32'(DE), 0);
    chk("hblk_hs", 32'(HS_OUT), 1);

    // Vertical blank forces black.
    @(negedge CLK);
    VIDEO_R = 4'hA; BLKn = 1'b1; VBLKn = 1'b0; HSYNC = 1'b0;
    @(posedge CLK); #1;
    chk("vblk_r", 32'(R_OUT), 0);
    chk("vblk_vblank", 32'(VBLANK_OUT), 1);
    chk("vblk_hblank", 32'(HBLANK_OUT), 0);

    // CE held low: outputs frozen.
    @(negedge CLK);
    CE_PIXEL = 1'b0; VIDEO_R = 4'h7; VBLKn = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("ce_low_r", 32'(R_OUT), 0);
    chk("ce_low_vblank", 32'(VBLANK_OUT), 1);

    // Lock acquisition: SEARCH, MEASURE, then lock on the 3rd VSYNC edge.
    run_frame(HTOT, HTOT, LINES);
    chk("f1_locked", post_lk, 0);
    chk("f1_vs_out", post_vs, 1);
    run_frame(HTOT, HTOT, LINES);
    chk("f2_locked", post_lk, 0);
    run_frame(HTOT, HTOT, LINES);
    chk("f3_pre_locked", pre_lk, 0);
    chk("f3_locked", post_lk, 1);
    chk("f3_h_total", post_ht, HTOT);
    chk("f3_h_active", post_ha, HACT);
    chk("f3_v_total", post_vt, LINES);
    chk("f3_v_active", post_va, VACT);

    // One 385-pixel frame drops lock; two good frames regain it.
    run_frame(HTOT + 1, HTOT + 1, LINES);
    chk("f4_locked", post_lk, 1);
    run_frame(HTOT, HTOT, LINES);
    chk("f5_locked", post_lk, 0);
    chk("f5_h_total_kept", post_ht, HTOT);
    run_frame(HTOT, HTOT, LINES);
    chk("f6_locked", post_lk, 0);
    run_frame(HTOT, HTOT, LINES);
    chk("f7_locked", post_lk, 1);
    chk("f7_h_total", post_ht, HTOT);
    chk("f7_v_total", post_vt, LINES);

    // 1100-CE last lines: hcnt saturates at 1023 (a wrap would give 76).
    run_frame(HTOT, 1100, LINES);
    chk("f8_locked", post_lk, 1);
    run_frame(HTOT, 1100, LINES);
    chk("f9_locked", post_lk, 0);
    chk("f9_h_total_kept", post_ht, HTOT);
    run_frame(HTOT, HTOT, 3);
    chk("f10_locked", post_lk, 1);
    chk("f10_h_total_sat", post_ht, 1023);
    chk("f10_h_active", post_ha, HACT);
    chk("f10_v_total", post_vt, LINES);

    // Mid-frame asynchronous reset, then reacquire from SEARCH.
    @(negedge CLK); RST = 1'b1;
    #1;
    chk("midrst_locked", 32'(LOCKED), 0);
    chk("midrst_h_total", 32'(H_TOTAL), 0);
    chk("midrst_v_total", 32'(V_TOTAL), 0);
    chk("midrst_de", 32'(DE), 0);
    @(negedge CLK); CE_PIXEL = 1'b0;
    @(negedge CLK); RST = 1'b0;
    run_frame(HTOT, HTOT, LINES);
    chk("ra_locked", post_lk, 0);
    run_frame(HTOT, HTOT, LINES);
    chk("rb_locked", post_lk, 0);
    run_frame(HTOT, HTOT, 1);
    chk("rc_locked", post_lk, 1);
    chk("rc_h_total", post_ht, HTOT);
    chk("rc_v_active", post_va, VACT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
